// File: rtl/lut_scan_arbiter.sv
// lut_scan_arbiter
// Shared linear-scan engine for monotonic (x, y) lookup tables. Two requesters
// (0 = cosine table, 1 = arcsine table) share one combinational ROM port.
// The engine finds the first entry whose x is strictly greater than the key and
// returns that entry together with the one before it as interpolation endpoints.
// A key equal to an entry's x therefore lands that entry in x0/y0.
// No interpolation is done here; the requester owns the arithmetic.
module lut_scan_arbiter #(
  parameter int KEY_W  = 64,
  parameter int Y_W    = 64,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [KEY_W-1:0]  key0,
  input  logic              req1,
  input  logic [KEY_W-1:0]  key1,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_sel,
  input  logic [KEY_W-1:0]  rom_x,
  input  logic [Y_W-1:0]    rom_y,
  output logic              busy,
  output logic              done,
  output logic              rsp_id,
  output logic [KEY_W-1:0]  x0,
  output logic [Y_W-1:0]    y0,
  output logic [KEY_W-1:0]  x1,
  output logic [Y_W-1:0]    y1,
  output logic              oor_lo,
  output logic              oor_hi
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [KEY_W-1:0]   key_reg;
  logic               sel_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic               last_reg;     // channel served most recently
  logic [KEY_W-1:0]   cand_x_reg;   // entry k-1, kept while scanning
  logic [Y_W-1:0]     cand_y_reg;
  logic [KEY_W-1:0]   x0_reg, x1_reg;
  logic [Y_W-1:0]     y0_reg, y1_reg;
  logic               rsp_id_reg, oor_lo_reg, oor_hi_reg;

  logic grant_id;
  logic hit;
  logic at_last;

  // Round-robin only matters on a tie; a lone request always wins.
  assign grant_id = req1 & (~req0 | ~last_reg);
  assign hit      = rom_x > key_reg;
  assign at_last  = (addr_reg == ADDR_W'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: scan ends on the first strictly-greater entry or at the last entry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req0 | req1) state_next = SCAN;
      SCAN:    if (hit | at_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: grant/latch in IDLE, walk the table in SCAN, publish results on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg    <= '0;
      sel_reg    <= 1'b0;
      addr_reg   <= '0;
      last_reg   <= 1'b1;
      cand_x_reg <= '0;
      cand_y_reg <= '0;
      x0_reg     <= '0;
      y0_reg     <= '0;
      x1_reg     <= '0;
      y1_reg     <= '0;
      rsp_id_reg <= 1'b0;
      oor_lo_reg <= 1'b0;
      oor_hi_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0 | req1) begin
            key_reg  <= grant_id ? key1 : key0;
            sel_reg  <= grant_id;
            addr_reg <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            x1_reg     <= rom_x;
            y1_reg     <= rom_y;
            rsp_id_reg <= sel_reg;
            oor_hi_reg <= 1'b0;
            if (addr_reg == '0) begin
              // Key below the whole table: collapse both endpoints onto entry 0.
              x0_reg     <= rom_x;
              y0_reg     <= rom_y;
              oor_lo_reg <= 1'b1;
            end else begin
              x0_reg     <= cand_x_reg;
              y0_reg     <= cand_y_reg;
              oor_lo_reg <= 1'b0;
            end
          end else begin
            cand_x_reg <= rom_x;
            cand_y_reg <= rom_y;
            if (at_last) begin
              // Nothing exceeds the key: collapse both endpoints onto the last entry.
              x0_reg     <= rom_x;
              y0_reg     <= rom_y;
              x1_reg     <= rom_x;
              y1_reg     <= rom_y;
              rsp_id_reg <= sel_reg;
              oor_lo_reg <= 1'b0;
              oor_hi_reg <= 1'b1;
            end else begin
              addr_reg <= addr_reg + ADDR_W'(1);
            end
          end
        end
        DONE: last_reg <= sel_reg;
        default: ;
      endcase
    end
  end

  assign rom_addr = addr_reg;
  assign rom_sel  = sel_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign rsp_id   = rsp_id_reg;
  assign x0       = x0_reg;
  assign y0       = y0_reg;
  assign x1       = x1_reg;
  assign y1       = y1_reg;
  assign oor_lo   = oor_lo_reg;
  assign oor_hi   = oor_hi_reg;

endmodule

// File: tb/tb_lut_scan_arbiter.sv
// Testbench for lut_scan_arbiter: behavioural ROM, reference lookup model and
// an expected-result queue filled when a request is issued.
module tb_lut_scan_arbiter;
  localparam int KEY_W  = 64;
  localparam int Y_W    = 64;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [KEY_W-1:0]  key0, key1;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_sel;
  logic [KEY_W-1:0]  rom_x;
  logic [Y_W-1:0]    rom_y;
  logic              busy, done, rsp_id;
  logic [KEY_W-1:0]  x0, x1;
  logic [Y_W-1:0]    y0, y1;
  logic              oor_lo, oor_hi;

  logic [KEY_W-1:0] tbl_x [2][DEPTH];
  logic [Y_W-1:0]   tbl_y [2][DEPTH];

  typedef struct packed {
    logic             id;
    logic [KEY_W-1:0] x0;
    logic [Y_W-1:0]   y0;
    logic [KEY_W-1:0] x1;
    logic [Y_W-1:0]   y1;
    logic             lo;
    logic             hi;
  } res_t;

  res_t exp_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   errors = 0;

  lut_scan_arbiter #(.KEY_W(KEY_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .key0(key0), .req1(req1), .key1(key1),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_x(rom_x), .rom_y(rom_y),
    .busy(busy), .done(done), .rsp_id(rsp_id),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .oor_lo(oor_lo), .oor_hi(oor_hi)
  );

  always #5 clk = ~clk;

  assign rom_x = tbl_x[rom_sel][rom_addr];
  assign rom_y = tbl_y[rom_sel][rom_addr];

  task automatic load_table(input int sel, input int base);
    for (int i = 0; i < DEPTH; i++) begin
      tbl_x[sel][i] = 64'(base + 10 * i);
      tbl_y[sel][i] = 64'(100 * (base + 10 * i));
    end
  endtask

  // Reference: first entry with x strictly greater than key; latency in edges.
  function automatic res_t model(input logic id, input logic [KEY_W-1:0] key, output int lat);
    res_t r;
    int k = -1;
    for (int i = 0; i < DEPTH; i++)
      if (k < 0 && tbl_x[id][i] > key) k = i;
    r.id = id; r.lo = 1'b0; r.hi = 1'b0;
    if (k == 0) begin
      r.x0 = tbl_x[id][0]; r.y0 = tbl_y[id][0];
      r.x1 = tbl_x[id][0]; r.y1 = tbl_y[id][0];
      r.lo = 1'b1; lat = 2;
    end else if (k < 0) begin
      r.x0 = tbl_x[id][DEPTH-1]; r.y0 = tbl_y[id][DEPTH-1];
      r.x1 = tbl_x[id][DEPTH-1]; r.y1 = tbl_y[id][DEPTH-1];
      r.hi = 1'b1; lat = DEPTH + 1;
    end else begin
      r.x0 = tbl_x[id][k-1]; r.y0 = tbl_y[id][k-1];
      r.x1 = tbl_x[id][k];   r.y1 = tbl_y[id][k];
      lat = k + 2;
    end
    return r;
  endfunction

  task automatic push(input logic id, input logic [KEY_W-1:0] key);
    int l;
    res_t r;
    r = model(id, key, l);
    exp_q.push_back(r);
    lat_q.push_back(l);
  endtask

  // Waits (bounded) for done; records edge count and whether the scan walked 0,1,2.. on sel.
  task automatic wait_done(input logic sel, output int edges, output bit walk_bad);
    int idx = 0;
    edges = 0;
    walk_bad = 1'b0;
    while (edges < 400) begin
      @(posedge clk); #1;
      edges++;
      if (done) return;
      if (busy) begin
        if (rom_addr !== idx[ADDR_W-1:0] || rom_sel !== sel) walk_bad = 1'b1;
        idx++;
      end
    end
    checks++; errors++;
    $display("FAIL done_timeout sel=%0d waited=%0d edges required<400", sel, edges);
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; key0 = '0; key1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got busy/done=%b required=00", {busy, done});
    end
    checks++;
    if ({rsp_id, x0, y0, x1, y1, oor_lo, oor_hi} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h required=0", {rsp_id, x0, y0, x1, y1, oor_lo, oor_hi});
    end
    checks++;
    if ({rom_sel, rom_addr} !== '0) begin
      errors++; $display("FAIL reset_rom got sel/addr=%h required=0", {rom_sel, rom_addr});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    $display("reset: busy=%0d done=%0d", busy, done);
  endtask

  task automatic test_single();
    int edges; bit wb; res_t got, e; int lat;
    push(1'b0, 64'd25);
    req0 = 1'b1; key0 = 64'd25;
    wait_done(1'b0, edges, wb);
    req0 = 1'b0;
    got = {rsp_id, x0, y0, x1, y1, oor_lo, oor_hi};
    e = exp_q.pop_front(); lat = lat_q.pop_front();
    $display("single: key=25 x0=%0d y0=%0d x1=%0d y1=%0d id=%0d edges=%0d", x0, y0, x1, y1, rsp_id, edges);
    checks++;
    if (got !== e) begin errors++; $display("FAIL single_result got=%h required=%h", got, e); end
    checks++;
    if (edges !== lat) begin errors++; $display("FAIL single_latency got=%0d required=%0d", edges, lat); end
    checks++;
    if (wb) begin errors++; $display("FAIL single_addr_walk got=bad required=0..k on sel 0"); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || x0 !== e.x0 || y1 !== e.y1) begin
      errors++; $display("FAIL single_hold got done=%0d x0=%0d y1=%0d required done=0 x0=%0d y1=%0d", done, x0, y1, e.x0, e.y1);
    end
  endtask

  task automatic test_equality();
    int edges; bit wb; res_t got, e; int lat;
    push(1'b1, 64'd30);
    req1 = 1'b1; key1 = 64'd30;
    wait_done(1'b1, edges, wb);
    req1 = 1'b0;
    got = {rsp_id, x0, y0, x1, y1, oor_lo, oor_hi};
    e = exp_q.pop_front(); lat = lat_q.pop_front();
    $display("equality: key=30 x0=%0d x1=%0d id=%0d edges=%0d", x0, x1, rsp_id, edges);
    checks++;
    if (got !== e) begin errors++; $display("FAIL equality_result got=%h required=%h", got, e); end
    checks++;
    if (edges !== lat) begin errors++; $display("FAIL equality_latency got=%0d required=%0d", edges, lat); end
    checks++;
    if (wb) begin errors++; $display("FAIL equality_addr_walk got=bad required=0..k on sel 1"); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int edges; bit wb; res_t got, e; int lat;
    logic exp_ids [4];
    exp_ids[0] = 1'b0; exp_ids[1] = 1'b1; exp_ids[2] = 1'b0; exp_ids[3] = 1'b1;
    push(1'b0, 64'd5); push(1'b1, 64'd15);
    req0 = 1'b1; key0 = 64'd5; req1 = 1'b1; key1 = 64'd15;
    for (int n = 0; n < 4; n++) begin
      wait_done(exp_ids[n], edges, wb);
      got = {rsp_id, x0, y0, x1, y1, oor_lo, oor_hi};
      e = exp_q.pop_front(); lat = lat_q.pop_front();
      $display("contention[%0d]: id=%0d x0=%0d x1=%0d", n, rsp_id, x0, x1);
      checks++;
      if (got !== e) begin errors++; $display("FAIL contention_result[%0d] got=%h required=%h", n, got, e); end
      checks++;
      if (wb) begin errors++; $display("FAIL contention_addr_walk[%0d] got=bad required=0..k on sel %0d", n, exp_ids[n]); end
      if (n == 0) req0 = 1'b0;
      if (n == 1) begin
        // Both channels request again; channel 0 must win after channel 1 was served.
        push(1'b0, 64'd45); push(1'b1, 64'd55);
        req0 = 1'b1; key0 = 64'd45; key1 = 64'd55;
      end
      if (n == 2) req0 = 1'b0;
      if (n == 3) req1 = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bounds();
    int edges; bit wb; res_t got, e; int lat;
    load_table(0, 5);
    push(1'b0, 64'd2);
    req0 = 1'b1; key0 = 64'd2;
    wait_done(1'b0, edges, wb);
    req0 = 1'b0;
    got = {rsp_id, x0, y0, x1, y1, oor_lo, oor_hi};
    e = exp_q.pop_front(); lat = lat_q.pop_front();
    $display("bounds_lo: key=2 x0=%0d x1=%0d oor_lo=%0d edges=%0d", x0, x1, oor_lo, edges);
    checks++;
    if (got !== e) begin errors++; $display("FAIL bounds_lo_result got=%h required=%h", got, e); end
    checks++;
    if (edges !== lat) begin errors++; $display("FAIL bounds_lo_latency got=%0d required=%0d", edges, lat); end
    @(posedge clk); #1;
    load_table(0, 0);
    push(1'b1, 64'd5000);
    req1 = 1'b1; key1 = 64'd5000;
    wait_done(1'b1, edges, wb);
    req1 = 1'b0;
    got = {rsp_id, x0, y0, x1, y1, oor_lo, oor_hi};
    e = exp_q.pop_front(); lat = lat_q.pop_front();
    $display("bounds_hi: key=5000 x0=%0d x1=%0d oor_hi=%0d edges=%0d", x0, x1, oor_hi, edges);
    checks++;
    if (got !== e) begin errors++; $display("FAIL bounds_hi_result got=%h required=%h", got, e); end
    checks++;
    if (edges !== lat) begin errors++; $display("FAIL bounds_hi_latency got=%0d required=%0d", edges, lat); end
    checks++;
    if (wb) begin errors++; $display("FAIL bounds_hi_addr_walk got=bad required=0..127 on sel 1"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    int edges; bit wb; res_t got, e; int lat; int n; bit saw_done;
    req0 = 1'b1; key0 = 64'd1000;
    n = 0;
    while (n < 50 && !(busy && rom_addr == 7'd6)) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!(busy && rom_addr == 7'd6)) begin
      errors++; $display("FAIL mid_reach_addr6 got addr=%0d busy=%0d required addr=6 busy=1", rom_addr, busy);
    end
    reset = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset_mid: busy=%0d done=%0d x0=%0d", busy, done, x0);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mid_flags got busy/done=%b required=00", {busy, done}); end
    checks++;
    if ({rsp_id, x0, y0, x1, y1, oor_lo, oor_hi, rom_addr, rom_sel} !== '0) begin
      errors++; $display("FAIL mid_outputs got=%h required=0", {rsp_id, x0, y0, x1, y1, oor_lo, oor_hi, rom_addr, rom_sel});
    end
    saw_done = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (done || busy) saw_done = 1'b1; end
    checks++;
    if (saw_done) begin errors++; $display("FAIL mid_no_done got activity required idle"); end
    push(1'b1, 64'd25);
    req1 = 1'b1; key1 = 64'd25;
    wait_done(1'b1, edges, wb);
    req1 = 1'b0;
    got = {rsp_id, x0, y0, x1, y1, oor_lo, oor_hi};
    e = exp_q.pop_front(); lat = lat_q.pop_front();
    $display("after_reset: key=25 id=%0d x0=%0d x1=%0d edges=%0d", rsp_id, x0, x1, edges);
    checks++;
    if (got !== e) begin errors++; $display("FAIL after_reset_result got=%h required=%h", got, e); end
    checks++;
    if (edges !== lat) begin errors++; $display("FAIL after_reset_latency got=%0d required=%0d", edges, lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    load_table(0, 0);
    load_table(1, 0);
    test_reset();
    test_single();
    test_equality();
    test_contention();
    test_bounds();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
